// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter
//   Shares one AXI3 master port between the ICache read path, the DCache read
//   path and the DCache write-back path. One read burst and one write burst may
//   be outstanding at a time. A read to the line currently being written back
//   is held off until the write has completed.
//
// Ports
//   aclk, aresetn                      clock, asynchronous active-low reset
//   ic_rd_* / dc_rd_*                  cache read requests (req/addr/len in, gnt out)
//   ret_data, *_ret_valid, ret_last    read beats steered back to the owner
//   dc_wr_*                            write-back request, beat data/strobe,
//                                      per-beat advance (dnext), completion (done)
//   ar*/r*, aw*/w*/b*                  AXI3 master channels
module axi_master_arbiter #(
    parameter int LINE_OFF = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ic_rd_req,
    input  logic [31:0] ic_rd_addr,
    input  logic [7:0]  ic_rd_len,
    output logic        ic_rd_gnt,
    input  logic        dc_rd_req,
    input  logic [31:0] dc_rd_addr,
    input  logic [7:0]  dc_rd_len,
    output logic        dc_rd_gnt,
    output logic [31:0] ret_data,
    output logic        ic_ret_valid,
    output logic        dc_ret_valid,
    output logic        ret_last,
    input  logic        dc_wr_req,
    input  logic [31:0] dc_wr_addr,
    input  logic [7:0]  dc_wr_len,
    output logic        dc_wr_gnt,
    input  logic [31:0] dc_wr_data,
    input  logic [3:0]  dc_wr_strb,
    output logic        dc_wr_dnext,
    output logic        dc_wr_done,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_B = 2'd3} wr_state_t;

    // True when both addresses fall in the same cache line.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:LINE_OFF] == b[31:LINE_OFF];
    endfunction

    rd_state_t   rd_state_r;
    wr_state_t   wr_state_r;
    logic        run_r;
    logic [31:0] rd_addr_r;
    logic [7:0]  rd_len_r;
    logic        rd_id_r;
    logic        arvalid_r;
    logic        rready_r;
    logic [31:0] wr_addr_r;
    logic [7:0]  wr_len_r;
    logic [7:0]  wr_cnt_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;
    logic        wr_done_r;

    logic        wr_gnt_s;
    logic        dc_blk_s;
    logic        ic_blk_s;
    logic        rd_idle_s;
    logic        dc_rd_gnt_s;
    logic        ic_rd_gnt_s;
    logic        r_beat_s;
    logic        w_hs_s;
    logic        wlast_s;
    logic        unused_s;

    // Grants are decided in the idle cycle itself so a new read can be taken
    // the cycle after the previous rlast. run_r keeps every output at 0 until
    // the first edge after reset release.
    assign wr_gnt_s    = run_r & (wr_state_r == W_IDLE) & dc_wr_req;
    // A read is blocked by an in-flight write to its line, or by a write to
    // its line being granted in this very cycle.
    assign dc_blk_s    = ((wr_state_r != W_IDLE) & same_line(dc_rd_addr, wr_addr_r)) |
                         (wr_gnt_s & same_line(dc_rd_addr, dc_wr_addr));
    assign ic_blk_s    = ((wr_state_r != W_IDLE) & same_line(ic_rd_addr, wr_addr_r)) |
                         (wr_gnt_s & same_line(ic_rd_addr, dc_wr_addr));
    assign rd_idle_s   = run_r & (rd_state_r == R_IDLE);
    assign dc_rd_gnt_s = rd_idle_s & dc_rd_req & ~dc_blk_s;
    assign ic_rd_gnt_s = rd_idle_s & ic_rd_req & ~ic_blk_s & ~dc_rd_gnt_s;
    assign r_beat_s    = rready_r & rvalid;
    assign w_hs_s      = wvalid_r & wready;
    assign wlast_s     = wvalid_r & (wr_cnt_r == wr_len_r);
    assign unused_s    = &{1'b0, rid, rresp, bid, bresp};

    // Marks the block as running from the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Read FSM: arbitration, AR handshake, R beat collection.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_r <= R_IDLE;
            rd_addr_r  <= 32'h0000_0000;
            rd_len_r   <= 8'h00;
            rd_id_r    <= 1'b0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (dc_rd_gnt_s) begin
                        rd_addr_r  <= dc_rd_addr;
                        rd_len_r   <= dc_rd_len;
                        rd_id_r    <= 1'b1;
                        arvalid_r  <= 1'b1;
                        rd_state_r <= R_AR;
                    end else if (ic_rd_gnt_s) begin
                        rd_addr_r  <= ic_rd_addr;
                        rd_len_r   <= ic_rd_len;
                        rd_id_r    <= 1'b0;
                        arvalid_r  <= 1'b1;
                        rd_state_r <= R_AR;
                    end else begin
                        rd_state_r <= R_IDLE;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid_r  <= 1'b0;
                        rready_r   <= 1'b1;
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_beat_s && rlast) begin
                        rready_r   <= 1'b0;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    arvalid_r  <= 1'b0;
                    rready_r   <= 1'b0;
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    // Write FSM: AW handshake, counted W beats, B response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_r <= W_IDLE;
            wr_addr_r  <= 32'h0000_0000;
            wr_len_r   <= 8'h00;
            wr_cnt_r   <= 8'h00;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            wr_done_r  <= 1'b0;
        end else begin
            wr_done_r <= 1'b0;
            case (wr_state_r)
                W_IDLE: begin
                    if (wr_gnt_s) begin
                        wr_addr_r  <= dc_wr_addr;
                        wr_len_r   <= dc_wr_len;
                        wr_cnt_r   <= 8'h00;
                        awvalid_r  <= 1'b1;
                        wr_state_r <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid_r  <= 1'b0;
                        wvalid_r   <= 1'b1;
                        wr_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        wr_cnt_r <= wr_cnt_r + 8'h01;
                        if (wlast_s) begin
                            wvalid_r   <= 1'b0;
                            bready_r   <= 1'b1;
                            wr_state_r <= W_B;
                        end
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        bready_r   <= 1'b0;
                        wr_done_r  <= 1'b1;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awvalid_r  <= 1'b0;
                    wvalid_r   <= 1'b0;
                    bready_r   <= 1'b0;
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

    assign ic_rd_gnt    = ic_rd_gnt_s;
    assign dc_rd_gnt    = dc_rd_gnt_s;
    assign dc_wr_gnt    = wr_gnt_s;
    // Beats are steered by the latched requester id; rid is not consulted.
    assign ret_data     = r_beat_s ? rdata : 32'h0000_0000;
    assign ic_ret_valid = r_beat_s & ~rd_id_r;
    assign dc_ret_valid = r_beat_s & rd_id_r;
    assign ret_last     = r_beat_s & rlast;
    assign dc_wr_dnext  = w_hs_s;
    assign dc_wr_done   = wr_done_r;

    assign arid    = {3'b000, rd_id_r};
    assign araddr  = rd_addr_r;
    assign arlen   = rd_len_r;
    assign arsize  = run_r ? 3'd2 : 3'd0;
    assign arburst = {1'b0, run_r};
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;

    assign awid    = {3'b000, run_r};
    assign awaddr  = wr_addr_r;
    assign awlen   = wr_len_r;
    assign awsize  = run_r ? 3'd2 : 3'd0;
    assign awburst = {1'b0, run_r};
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = awvalid_r;
    assign wid     = {3'b000, run_r};
    assign wdata   = wvalid_r ? dc_wr_data : 32'h0000_0000;
    assign wstrb   = wvalid_r ? dc_wr_strb : 4'b0000;
    assign wlast   = wlast_s;
    assign wvalid  = wvalid_r;
    assign bready  = bready_r;

endmodule
